fetch_sequencer: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the execute/memory backend. It owns the PC and fetches instructions over a request/acknowledge handshake. It latches the instruction word for the decoder and steps each instruction through DECODE, EXEC and COMMIT. It resolves branches and jumps from the backend's active-low compare flags, and performs trap entry and return.

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/exec/commit sequencer with branch resolution and trap entry/return
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic [31:0] alu_result,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic        gpr_we_n,
    output logic        csr_we_n,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        mepc_we_n,
    output logic [31:0] mepc_wdata,
    output logic [31:0] mcause_wdata,
    output logic        retire
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, COMMIT, TRAP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, inst_q, link_q, next_pc_q, mepc_wdata_q, mcause_wdata_q;
    logic        imem_req_q, gpr_we_n_q, csr_we_n_q, mepc_we_n_q, retire_q;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_j, imm_b, target, next_pc_d, cause_d, tvec;
    logic        is_br, is_jal, is_jalr, is_sys, is_csr, is_ecall, is_ebreak, is_mret;
    logic        legal, taken, redirect, trap_d, wr_rd;

    assign opc       = inst_q[6:0];
    assign f3        = inst_q[14:12];
    assign imm_j     = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign imm_b     = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign tvec      = mtvec & ~32'h3;
    assign is_br     = opc == OP_BRANCH;
    assign is_jal    = opc == OP_JAL;
    assign is_jalr   = opc == OP_JALR;
    assign is_sys    = opc == OP_SYSTEM;
    assign is_csr    = is_sys && f3 != 3'b000;
    assign is_ecall  = is_sys && f3 == 3'b000 && inst_q[31:20] == 12'h000;
    assign is_ebreak = is_sys && f3 == 3'b000 && inst_q[31:20] == 12'h001;
    assign is_mret   = is_sys && f3 == 3'b000 && inst_q[31:20] == 12'h302;
    assign legal     = opc == OP_LUI || opc == OP_AUIPC || is_jal || is_jalr || is_br || opc == OP_LOAD ||
                       opc == OP_STORE || opc == OP_IMM || opc == OP_OP || is_sys || opc == OP_MISC;
    assign wr_rd     = inst_q[11:7] != 5'd0 && (opc == OP_LUI || opc == OP_AUIPC || is_jal || is_jalr ||
                       opc == OP_LOAD || opc == OP_OP || opc == OP_IMM || is_csr);

    // Branch resolution from the active-low flags, next-PC selection and trap decision for DECODE/EXEC
    always_comb begin
        taken     = f3[2] ? ((f3[1] ? is_ltu : is_lt) ^ ~f3[0]) : (is_zero ^ ~f3[0]);
        redirect  = is_jal || is_jalr || (is_br && taken);
        target    = is_jalr ? (alu_result & ~32'h1) : pc_q + (is_jal ? imm_j : imm_b);
        next_pc_d = is_mret ? mepc : redirect ? target : pc_q + 32'd4;
        trap_d    = (state_q == DECODE) ? (!legal || (is_br && f3[2:1] == 2'b01))
                                        : ((redirect && !is_jalr && target[1]) || is_ecall || is_ebreak);
        cause_d   = (state_q == DECODE) ? 32'd2 : is_ecall ? 32'd11 : is_ebreak ? 32'd3 : 32'd0;
    end

    // Sequencer state, PC, instruction latch and every registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            link_q         <= RESET_PC + 32'd4;
            next_pc_q      <= RESET_PC;
            inst_q         <= NOP_INST;
            imem_req_q     <= 1'b0;
            gpr_we_n_q     <= 1'b1;
            csr_we_n_q     <= 1'b1;
            mepc_we_n_q    <= 1'b1;
            retire_q       <= 1'b0;
            mepc_wdata_q   <= 32'd0;
            mcause_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        inst_q     <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE, EXEC: begin
                    if (trap_d) begin
                        state_q        <= TRAP;
                        mepc_we_n_q    <= 1'b0;
                        mepc_wdata_q   <= pc_q;
                        mcause_wdata_q <= cause_d;
                    end else if (state_q == DECODE) begin
                        state_q <= EXEC;
                    end else begin
                        state_q    <= COMMIT;
                        next_pc_q  <= next_pc_d;
                        gpr_we_n_q <= !wr_rd;
                        csr_we_n_q <= !is_csr;
                        retire_q   <= 1'b1;
                    end
                end
                COMMIT: begin
                    pc_q       <= next_pc_q;
                    link_q     <= next_pc_q + 32'd4;
                    gpr_we_n_q <= 1'b1;
                    csr_we_n_q <= 1'b1;
                    retire_q   <= 1'b0;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                TRAP: begin
                    pc_q        <= tvec;
                    link_q      <= tvec + 32'd4;
                    mepc_we_n_q <= 1'b1;
                    imem_req_q  <= 1'b1;
                    state_q     <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign pc           = pc_q;
    assign link_addr    = link_q;
    assign gpr_we_n     = gpr_we_n_q;
    assign csr_we_n     = csr_we_n_q;
    assign mepc_we_n    = mepc_we_n_q;
    assign mepc_wdata   = mepc_wdata_q;
    assign mcause_wdata = mcause_wdata_q;
    assign retire       = retire_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed program with a scoreboard of expected fetches and commit/trap events
module tb_fetch_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack, gpr_we_n, csr_we_n, mepc_we_n, retire;
    logic        is_lt, is_ltu, is_zero;
    logic [31:0] imem_addr, imem_rdata, inst, pc, link_addr, alu_result, mtvec, mepc, mepc_wdata, mcause_wdata;

    typedef struct {
        bit          trap;
        logic        gw, cw;
        logic [31:0] link, mepc, cause;
    } evt_t;

    typedef struct {
        logic [31:0] pc, inst;
        int          dly;
        logic        z, lt, ltu;
        logic [31:0] alu;
        bit          trap;
        logic        gw, cw;
        logic [31:0] cause, nxt;
    } vec_t;

    logic [31:0] fq[$];
    evt_t        eq[$];
    vec_t        vt[23];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic        req_prev = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .pc(pc), .link_addr(link_addr), .alu_result(alu_result),
        .is_lt(is_lt), .is_ltu(is_ltu), .is_zero(is_zero), .gpr_we_n(gpr_we_n), .csr_we_n(csr_we_n),
        .mtvec(mtvec), .mepc(mepc), .mepc_we_n(mepc_we_n), .mepc_wdata(mepc_wdata),
        .mcause_wdata(mcause_wdata), .retire(retire)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic [31:0] p, i, input int d, input logic z, lt, ltu,
                               input logic [31:0] alu, input bit tr, input logic gw, cw,
                               input logic [31:0] cause, nxt);
        v = '{p, i, d, z, lt, ltu, alu, tr, gw, cw, cause, nxt};
    endfunction

    // Monitor: pops the scoreboard whenever a fetch starts or a commit/trap strobe appears
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && !req_prev) begin
                if (fq.size() == 0) chk("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
                else chk("fetch_addr", imem_addr, fq.pop_front());
            end
            if (retire || !mepc_we_n) begin
                if (eq.size() == 0) begin
                    chk("event_unexpected", {30'd0, retire, mepc_we_n}, 32'd1);
                end else begin
                    chk("is_trap", {31'd0, !mepc_we_n}, {31'd0, eq[0].trap});
                    if (eq[0].trap) begin
                        chk("mepc_wdata", mepc_wdata, eq[0].mepc);
                        chk("mcause_wdata", mcause_wdata, eq[0].cause);
                        chk("trap_gpr_we_n", {31'd0, gpr_we_n}, 32'd1);
                        chk("trap_retire", {31'd0, retire}, 32'd0);
                    end else begin
                        chk("gpr_we_n", {31'd0, gpr_we_n}, {31'd0, eq[0].gw});
                        chk("csr_we_n", {31'd0, csr_we_n}, {31'd0, eq[0].cw});
                        chk("link_addr", link_addr, eq[0].link);
                    end
                    void'(eq.pop_front());
                end
            end
        end
        req_prev <= imem_req;
    end

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        chk("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic issue(input vec_t t);
        is_zero    = t.z;
        is_lt      = t.lt;
        is_ltu     = t.ltu;
        alu_result = t.alu;
        eq.push_back('{t.trap, t.gw, t.cw, t.pc + 32'd4, t.pc, t.cause});
        fq.push_back(t.nxt);
        wait_req();
        repeat (t.dly) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = t.inst;
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && !(retire || !mepc_we_n); i++) @(negedge clk);
        chk("done_wait", {31'd0, retire || !mepc_we_n}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vt[0]  = v(32'h0000_0000, 32'h0050_0093, 2, 1, 1, 1, 32'h0,         0, 0, 1, 0,  32'h0000_0004);
        vt[1]  = v(32'h0000_0004, 32'h00C0_006F, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0010);
        vt[2]  = v(32'h0000_0010, 32'h0000_0463, 1, 0, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0018);
        vt[3]  = v(32'h0000_0018, 32'h0000_0463, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_001C);
        vt[4]  = v(32'h0000_001C, 32'h0000_6463, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0020);
        vt[5]  = v(32'h0000_0020, 32'h0000_7463, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0028);
        vt[6]  = v(32'h0000_0028, 32'h0000_4463, 0, 1, 0, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0030);
        vt[7]  = v(32'h0000_0030, 32'h0000_00E7, 0, 1, 1, 1, 32'h0000_0103, 0, 0, 1, 0,  32'h0000_0102);
        vt[8]  = v(32'h0000_0102, 32'h0000_0067, 0, 1, 1, 1, 32'h0000_0040, 0, 1, 1, 0,  32'h0000_0040);
        vt[9]  = v(32'h0000_0040, 32'h0000_0073, 0, 1, 1, 1, 32'h0,         1, 1, 1, 11, 32'h0000_0200);
        vt[10] = v(32'h0000_0200, 32'h3020_0073, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0044);
        vt[11] = v(32'h0000_0044, 32'h0000_0000, 1, 1, 1, 1, 32'h0,         1, 1, 1, 2,  32'h0000_0200);
        vt[12] = v(32'h0000_0200, 32'h0020_006F, 0, 1, 1, 1, 32'h0,         1, 1, 1, 0,  32'h0000_0200);
        vt[13] = v(32'h0000_0200, 32'h0010_0073, 0, 1, 1, 1, 32'h0,         1, 1, 1, 3,  32'h0000_0200);
        vt[14] = v(32'h0000_0200, 32'h3400_92F3, 0, 1, 1, 1, 32'h0,         0, 0, 0, 0,  32'h0000_0204);
        vt[15] = v(32'h0000_0204, 32'h0000_2463, 0, 1, 1, 1, 32'h0,         1, 1, 1, 2,  32'h0000_0200);
        vt[16] = v(32'h0000_0200, 32'h0000_2023, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0204);
        vt[17] = v(32'h0000_0204, 32'h0000_01B7, 0, 1, 1, 1, 32'h0,         0, 0, 1, 0,  32'h0000_0208);
        vt[18] = v(32'h0000_0208, 32'h0000_5463, 0, 1, 1, 1, 32'h0,         0, 1, 1, 0,  32'h0000_0210);
        vt[19] = v(32'h0000_0210, 32'h0000_0067, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 1, 1, 0,  32'hFFFF_FFFC);
        vt[20] = v(32'hFFFF_FFFC, 32'h0050_0093, 1, 1, 1, 1, 32'h0,         0, 0, 1, 0,  32'h0000_0000);
        vt[21] = v(32'h0000_0000, 32'h0050_0093, 0, 1, 1, 1, 32'h0,         0, 0, 1, 0,  32'h0000_0004);
        vt[22] = v(32'h0000_0000, 32'h0050_0093, 1, 1, 1, 1, 32'h0,         0, 0, 1, 0,  32'h0000_0004);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        is_zero    = 1'b1;
        is_lt      = 1'b1;
        is_ltu     = 1'b1;
        alu_result = 32'h0;
        mtvec      = 32'h0000_0201;
        mepc       = 32'h0000_0044;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_strobes", {28'd0, gpr_we_n, csr_we_n, mepc_we_n, retire}, 32'hE);
        chk("rst_mepc_wdata", mepc_wdata, 32'h0);
        chk("rst_mcause_wdata", mcause_wdata, 32'h0);
        fq.push_back(32'h0);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            issue(vt[i]);
            if (i == 0) begin
                wait_req();
                chk("first_inst_cycles", cyc, 32'd7);
            end
        end
        wait_req();
        @(negedge clk);
        chk("mid_fetch_pc", pc, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_strobes", {28'd0, gpr_we_n, csr_we_n, mepc_we_n, retire}, 32'hE);
        @(negedge clk);
        fq.push_back(32'h0);
        rst = 1'b0;
        issue(vt[22]);
        wait_req();
        @(negedge clk);
        chk("fetch_q_empty", fq.size(), 32'd0);
        chk("event_q_empty", eq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
